// File: rtl/nn_pkg.sv
// Shared definitions for the neuron datapath: FSM state codes, index width and
// the default geometry used by the selection stage and the layer controller.
package nn_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ACC  = 2'd1;
  localparam state_t ST_FIN  = 2'd2;

  localparam int OFFSET_W  = 6;
  localparam int DEF_N     = 10;
  localparam int DEF_DW    = 8;
  localparam int DEF_ACC_W = 24;

endpackage

// File: rtl/relu_sat.sv
// Output stage of a neuron: add bias to the accumulated sum, clamp negatives to
// zero, rescale by an arithmetic right shift and saturate to the positive range.
module relu_sat #(
  parameter int DW    = 8,
  parameter int ACC_W = 24,
  parameter int SHIFT = 0
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [DW-1:0]    i_bias,
  output logic [DW-1:0]    o_val
);

  localparam logic [DW-1:0]    OUT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [ACC_W-1:0] W_MAX   = {{(ACC_W-DW){1'b0}}, OUT_MAX};

  logic [ACC_W-1:0] w_bias_ext;
  logic [ACC_W-1:0] w_sum;
  logic [ACC_W-1:0] w_pos;
  logic [ACC_W-1:0] w_shift;

  assign w_bias_ext = {{(ACC_W-DW){i_bias[DW-1]}}, i_bias};
  assign w_sum      = i_acc + w_bias_ext;
  assign w_pos      = w_sum[ACC_W-1] ? '0 : w_sum;
  // w_pos is non-negative, so a logical shift matches the arithmetic one
  assign w_shift    = w_pos >> SHIFT;
  assign o_val      = (w_shift > W_MAX) ? OUT_MAX : w_shift[DW-1:0];

endmodule

// File: rtl/neuron_mac.sv
// Sequential multiply-accumulate neuron: walks offsets 0..N-1 through the
// upstream selector, accumulates products, then emits ReLU(acc+bias) with a done pulse.
module neuron_mac
  import nn_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int DW    = DEF_DW,
  parameter int ACC_W = DEF_ACC_W,
  parameter int SHIFT = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [DW-1:0]       i_inp,
  input  logic [DW-1:0]       i_weight,
  input  logic [DW-1:0]       i_bias,
  output logic [OFFSET_W-1:0] o_offset,
  output logic                o_busy,
  output logic                o_done,
  output logic [DW-1:0]       o_out_val,
  output logic [1:0]          o_state
);

  localparam logic [OFFSET_W-1:0] LAST = OFFSET_W'(N-1);

  state_t              r_state;
  logic [OFFSET_W-1:0] r_offset;
  logic [ACC_W-1:0]    r_acc;
  logic [DW-1:0]       r_out;
  logic                r_done;

  logic signed [2*DW-1:0] w_prod;
  logic [ACC_W-1:0]       w_prod_ext;
  logic [DW-1:0]          w_relu;

  assign w_prod     = $signed(i_inp) * $signed(i_weight);
  assign w_prod_ext = {{(ACC_W-2*DW){w_prod[2*DW-1]}}, w_prod};

  relu_sat #(
    .DW    (DW),
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_relu_sat (
    .i_acc  (r_acc),
    .i_bias (i_bias),
    .o_val  (w_relu)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_offset <= '0;
      r_acc    <= '0;
      r_out    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_offset <= '0;
          if (i_start) begin
            r_acc   <= '0;
            r_state <= ST_ACC;
          end
        end
        ST_ACC: begin
          r_acc <= r_acc + w_prod_ext;
          // offset parks at N-1 during FIN so it never leaves 0..N-1
          if (r_offset == LAST) r_state <= ST_FIN;
          else r_offset <= r_offset + OFFSET_W'(1);
        end
        ST_FIN: begin
          r_out    <= w_relu;
          r_done   <= 1'b1;
          r_offset <= '0;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_offset <= '0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_offset  = r_offset;
  assign o_busy    = (r_state == ST_ACC) || (r_state == ST_FIN);
  assign o_done    = r_done;
  assign o_out_val = r_out;
  assign o_state   = r_state;

endmodule
